hub75_scan_ctrl: RTL and testbench

Scan sequencer for the HUB75 LED panel. It replaces free-running divided clocks with a single-clock state machine built on clock enables. For each row pair it fetches pixels from the frame buffer, shifts them out on a divided shift clock, blanks, latches, and drives the row address and output enable. It sits between the frame-buffer read port and the panel connector pins.

---
 rtl/hub75_scan_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_ctrl.sv
// -----------------------------------------------------------------------------
// hub75_scan_ctrl
// Single-clock scan sequencer for a HUB75 LED panel. For every row pair it
// reads each column from the frame buffer, shifts it out on a divided shift
// clock, blanks, latches, updates the row address and lights the row.
//
// Ports
//   clk_in       system clock, all logic on posedge
//   rst          synchronous active-high reset
//   enable       start / continue scanning (sampled in IDLE and at row end)
//   pix_req      frame-buffer read strobe (one cycle per column)
//   pix_col      column address of the read
//   pix_row      row address of the read
//   pix_rgb      {r1,g1,b1,r0,g0,b0}, valid exactly one cycle after pix_req
//   panel_clk    shift clock
//   panel_lat    latch strobe
//   panel_oe_n   output enable, active low
//   panel_addr   displayed row address
//   panel_rgb    shift data
//   frame_start  one-cycle pulse with the first read of each frame
//   busy         high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module hub75_scan_ctrl #(
  parameter int unsigned COLS         = 64,
  parameter int unsigned ROW_BITS     = 4,
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned OE_CYCLES    = 256
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    enable,
  output logic                    pix_req,
  output logic [$clog2(COLS)-1:0] pix_col,
  output logic [ROW_BITS-1:0]     pix_row,
  input  logic [5:0]              pix_rgb,
  output logic                    panel_clk,
  output logic                    panel_lat,
  output logic                    panel_oe_n,
  output logic [ROW_BITS-1:0]     panel_addr,
  output logic [5:0]              panel_rgb,
  output logic                    frame_start,
  output logic                    busy
);

  localparam int unsigned COL_W   = $clog2(COLS);
  localparam int unsigned MAX_A   = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int unsigned MAX_LEN = (MAX_A > OE_CYCLES) ? MAX_A : OE_CYCLES;
  localparam int unsigned CNT_NAT = $clog2(MAX_LEN + 1);
  localparam int unsigned CNT_W   = (CNT_NAT > 16) ? CNT_NAT : 16;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_SHIFT_LO = 3'd3;
  localparam logic [2:0] S_SHIFT_HI = 3'd4;
  localparam logic [2:0] S_BLANK    = 3'd5;
  localparam logic [2:0] S_LATCH    = 3'd6;
  localparam logic [2:0] S_DISPLAY  = 3'd7;

  // Sequencer state
  logic [2:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [COL_W-1:0]    r_col;
  logic [ROW_BITS-1:0] r_row;

  // Output registers
  logic                r_pix_req;
  logic [COL_W-1:0]    r_pix_col;
  logic [ROW_BITS-1:0] r_pix_row;
  logic                r_panel_clk;
  logic                r_panel_lat;
  logic                r_panel_oe_n;
  logic [ROW_BITS-1:0] r_panel_addr;
  logic [5:0]          r_panel_rgb;
  logic                r_frame_start;
  logic                r_busy;

  // Next-state values
  logic [2:0]          w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [COL_W-1:0]    w_col_nxt;
  logic [ROW_BITS-1:0] w_row_nxt;
  logic                w_phase_done;
  logic                w_addr_load;

  // Phase counter reload value: counts down to zero in the last cycle of a state.
  function automatic logic [CNT_W-1:0] phase_len(input logic [2:0] st);
    case (st)
      S_SHIFT_LO, S_SHIFT_HI: phase_len = CNT_W'(CLK_DIV - 1);
      S_BLANK:                phase_len = CNT_W'(BLANK_CYCLES - 1);
      S_DISPLAY:              phase_len = CNT_W'(OE_CYCLES - 1);
      default:                phase_len = '0;
    endcase
  endfunction

  // Next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_col_nxt    = r_col;
    w_row_nxt    = r_row;
    w_phase_done = (r_cnt == '0);
    w_addr_load  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (enable) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_state_nxt = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        if (w_phase_done) w_state_nxt = S_SHIFT_HI;
      end
      S_SHIFT_HI: begin
        if (w_phase_done) begin
          if (r_col == LAST_COL) begin
            w_col_nxt   = '0;
            w_state_nxt = S_BLANK;
          end else begin
            w_col_nxt   = r_col + COL_W'(1);
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_BLANK: begin
        if (w_phase_done) w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        w_state_nxt = S_DISPLAY;
      end
      S_DISPLAY: begin
        if (w_phase_done) begin
          w_row_nxt   = r_row + ROW_BITS'(1);
          w_state_nxt = enable ? S_FETCH : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Reload on every state entry; otherwise count down and park at zero.
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = phase_len(w_state_nxt);
    end else if (!w_phase_done) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end

    // Row address moves as the last BLANK cycle begins so it settles a full
    // cycle before the latch pulse while the panel is still dark.
    w_addr_load = (w_state_nxt == S_BLANK) && (w_cnt_nxt == '0);
  end

  // State and registered outputs, the latter decoded from the next state
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_pix_req     <= 1'b0;
      r_pix_col     <= '0;
      r_pix_row     <= '0;
      r_panel_clk   <= 1'b0;
      r_panel_lat   <= 1'b0;
      r_panel_oe_n  <= 1'b1;
      r_panel_addr  <= '0;
      r_panel_rgb   <= '0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;

      r_pix_req     <= (w_state_nxt == S_FETCH);
      r_frame_start <= (w_state_nxt == S_FETCH) && (w_row_nxt == '0) && (w_col_nxt == '0);
      if (w_state_nxt == S_FETCH) begin
        r_pix_col <= w_col_nxt;
        r_pix_row <= w_row_nxt;
      end

      r_panel_clk  <= (w_state_nxt == S_SHIFT_HI);
      r_panel_lat  <= (w_state_nxt == S_LATCH);
      r_panel_oe_n <= (w_state_nxt != S_DISPLAY);
      r_busy       <= (w_state_nxt != S_IDLE);

      // Read data arrives during WAIT and is held through the shift pulse.
      if (r_state == S_WAIT) r_panel_rgb <= pix_rgb;

      if (w_addr_load) r_panel_addr <= w_row_nxt;
    end
  end

  assign pix_req     = r_pix_req;
  assign pix_col     = r_pix_col;
  assign pix_row     = r_pix_row;
  assign panel_clk   = r_panel_clk;
  assign panel_lat   = r_panel_lat;
  assign panel_oe_n  = r_panel_oe_n;
  assign panel_addr  = r_panel_addr;
  assign panel_rgb   = r_panel_rgb;
  assign frame_start = r_frame_start;
  assign busy        = r_busy;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hub75_scan_ctrl
// Scoreboard bench: the frame-buffer responder pushes every pixel it returns
// into a queue; an independent monitor pops it at each panel_clk rise and
// checks addresses, timing and panel invariants from plain arithmetic on the
// scan geometry.
// -----------------------------------------------------------------------------
module tb_hub75_scan_ctrl;

  localparam int unsigned COLS         = 4;
  localparam int unsigned ROW_BITS     = 2;
  localparam int unsigned CLK_DIV      = 2;
  localparam int unsigned BLANK_CYCLES = 2;
  localparam int unsigned OE_CYCLES    = 8;

  localparam int ROWS       = 1 << ROW_BITS;
  localparam int COL_PERIOD = 2 + 2 * CLK_DIV;
  localparam int ROW_PERIOD = COLS * COL_PERIOD + BLANK_CYCLES + 1 + OE_CYCLES;
  localparam int FRAME      = ROWS * ROW_PERIOD;
  localparam int LAT_OFS    = COLS * COL_PERIOD + BLANK_CYCLES;

  logic                clk_in = 1'b0;
  logic                rst;
  logic                enable;
  logic                pix_req;
  logic [1:0]          pix_col;
  logic [ROW_BITS-1:0] pix_row;
  logic [5:0]          pix_rgb;
  logic                panel_clk;
  logic                panel_lat;
  logic                panel_oe_n;
  logic [ROW_BITS-1:0] panel_addr;
  logic [5:0]          panel_rgb;
  logic                frame_start;
  logic                busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int exp_rgb_q[$];
  int lat_q[$];
  int fs_q[$];

  hub75_scan_ctrl #(
    .COLS(COLS), .ROW_BITS(ROW_BITS), .CLK_DIV(CLK_DIV),
    .BLANK_CYCLES(BLANK_CYCLES), .OE_CYCLES(OE_CYCLES)
  ) dut (
    .clk_in(clk_in), .rst(rst), .enable(enable),
    .pix_req(pix_req), .pix_col(pix_col), .pix_row(pix_row), .pix_rgb(pix_rgb),
    .panel_clk(panel_clk), .panel_lat(panel_lat), .panel_oe_n(panel_oe_n),
    .panel_addr(panel_addr), .panel_rgb(panel_rgb),
    .frame_start(frame_start), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-buffer model: returns a random pixel one cycle after each read.
  initial begin : responder
    logic       pend;
    logic [5:0] v;
    pend    = 1'b0;
    pix_rgb = '0;
    forever begin
      @(posedge clk_in); #1;
      if (rst) begin
        pend = 1'b0;
        exp_rgb_q.delete();
        pix_rgb = 6'($urandom);
      end else begin
        if (pend) begin
          v       = 6'($urandom);
          pix_rgb = v;
          exp_rgb_q.push_back(int'(v));
          pend    = 1'b0;
        end else begin
          pix_rgb = 6'($urandom);
        end
        if (pix_req) pend = 1'b1;
      end
    end
  end

  // Monitor: reference scan model plus panel invariants.
  initial begin : monitor
    int m_idx, run_t0, run_row0, row_start_cyc, cur_row, last_fetch_cyc;
    int hi_run, oe_run, exp_v;
    logic p_clk, p_lat, p_oe_n, p_busy;
    logic [ROW_BITS-1:0] p_addr;
    logic [5:0] p_rgb;
    m_idx = 0; run_t0 = 0; run_row0 = 0; row_start_cyc = 0; cur_row = 0;
    last_fetch_cyc = 0; hi_run = 0; oe_run = 0;
    p_clk = 0; p_lat = 0; p_oe_n = 1; p_busy = 0; p_addr = '0; p_rgb = '0;
    forever begin
      @(posedge clk_in); #1;
      if (rst) begin
        m_idx = 0; hi_run = 0; oe_run = 0;
        p_clk = 0; p_lat = 0; p_oe_n = 1; p_busy = 0; p_addr = '0; p_rgb = '0;
        fs_q.delete();
        continue;
      end

      // Reads walk row-major through the frame; a run starts after idle.
      if (pix_req) begin
        check("fetch_row", 32'(pix_row), 32'((m_idx / COLS) % ROWS));
        check("fetch_col", 32'(pix_col), 32'(m_idx % COLS));
        if (!p_busy) begin
          run_t0   = cyc;
          run_row0 = m_idx / COLS;
        end else begin
          check("fetch_time", 32'(cyc),
                32'(run_t0 + (m_idx / COLS - run_row0) * ROW_PERIOD + (m_idx % COLS) * COL_PERIOD));
        end
        if (m_idx % COLS == 0) row_start_cyc = cyc;
        cur_row        = (m_idx / COLS) % ROWS;
        last_fetch_cyc = cyc;
      end
      check("frame_start", 32'(frame_start), 32'(pix_req && (m_idx % (COLS * ROWS) == 0)));
      if (frame_start) fs_q.push_back(cyc);
      if (pix_req) m_idx++;

      // Shift data and clock shape
      if (panel_clk && !p_clk) begin
        check("rgb_avail", 32'(exp_rgb_q.size() > 0), 32'd1);
        if (exp_rgb_q.size() > 0) begin
          exp_v = exp_rgb_q.pop_front();
          check("panel_rgb", 32'(panel_rgb), 32'(exp_v));
        end
        check("clk_setup", 32'(cyc - last_fetch_cyc), 32'(2 + CLK_DIV));
      end
      if (!panel_clk && p_clk) check("clk_hi_width", 32'(hi_run), 32'(CLK_DIV));
      hi_run = panel_clk ? hi_run + 1 : 0;
      if (panel_clk && p_clk) check("rgb_hold_hi", 32'(panel_rgb), 32'(p_rgb));

      // Latch
      if (panel_lat) begin
        check("lat_width", 32'(p_lat), 32'd0);
        check("lat_addr", 32'(panel_addr), 32'(cur_row));
        check("lat_time", 32'(cyc - row_start_cyc), 32'(LAT_OFS));
        check("addr_setup", 32'(panel_addr), 32'(p_addr));
        lat_q.push_back(int'(panel_addr));
      end

      // Lit period and dark-only invariants
      if (!panel_oe_n && p_oe_n) check("oe_after_lat", 32'(p_lat), 32'd1);
      if (panel_oe_n && !p_oe_n) check("oe_width", 32'(oe_run), 32'(OE_CYCLES));
      oe_run = panel_oe_n ? 0 : oe_run + 1;
      check("oe_lat_overlap", 32'(!panel_oe_n && panel_lat), 32'd0);
      if (panel_addr !== p_addr) check("addr_change_dark", 32'({p_oe_n, panel_oe_n}), 32'd3);

      p_clk = panel_clk; p_lat = panel_lat; p_oe_n = panel_oe_n;
      p_busy = busy; p_addr = panel_addr; p_rgb = panel_rgb;
    end
  end

  // Stimulus
  initial begin : stimulus
    int  t_f, lat_before;
    logic found;
    rst    = 1'b1;
    enable = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_pix_req", 32'(pix_req), 32'd0);
    check("rst_pix_col", 32'(pix_col), 32'd0);
    check("rst_pix_row", 32'(pix_row), 32'd0);
    check("rst_panel_clk", 32'(panel_clk), 32'd0);
    check("rst_panel_lat", 32'(panel_lat), 32'd0);
    check("rst_panel_oe_n", 32'(panel_oe_n), 32'd1);
    check("rst_panel_addr", 32'(panel_addr), 32'd0);
    check("rst_panel_rgb", 32'(panel_rgb), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk_in);
    check("first_pix_req", 32'(pix_req), 32'd1);
    check("first_pix_col", 32'(pix_col), 32'd0);
    check("first_pix_row", 32'(pix_row), 32'd0);
    check("first_frame_start", 32'(frame_start), 32'd1);

    // Five rows: address wraps, two frame starts one frame apart
    for (int k = 0; k < 6 * ROW_PERIOD && lat_q.size() < 5; k++) @(negedge clk_in);
    check("five_latches", 32'(lat_q.size() >= 5), 32'd1);
    if (lat_q.size() >= 5)
      for (int i = 0; i < 5; i++) check("lat_addr_seq", 32'(lat_q[i]), 32'(i % ROWS));
    check("fs_count", 32'(fs_q.size()), 32'd2);
    if (fs_q.size() >= 2) check("fs_spacing", 32'(fs_q[1] - fs_q[0]), 32'(FRAME));

    // Drop enable during SHIFT_LO of row 1, col 2
    found = 1'b0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      @(negedge clk_in);
      found = pix_req && (pix_row == 1) && (pix_col == 2);
    end
    check("found_r1c2", 32'(found), 32'd1);
    t_f        = cyc;
    lat_before = lat_q.size();
    @(negedge clk_in);
    @(negedge clk_in);
    enable = 1'b0;
    for (int k = 0; k < 3 * ROW_PERIOD && busy; k++) @(negedge clk_in);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_idle_time", 32'(cyc - t_f),
          32'((COLS - 2) * COL_PERIOD + BLANK_CYCLES + 1 + OE_CYCLES));
    check("drop_lat_count", 32'(lat_q.size() - lat_before), 32'd1);
    if (lat_q.size() > 0) check("drop_lat_addr", 32'(lat_q[$]), 32'd1);
    repeat (6) begin
      @(negedge clk_in);
      check("idle_pix_req", 32'(pix_req), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
    enable = 1'b1;
    @(negedge clk_in);
    check("resume_pix_req", 32'(pix_req), 32'd1);
    check("resume_pix_row", 32'(pix_row), 32'd2);
    check("resume_pix_col", 32'(pix_col), 32'd0);
    check("resume_frame_start", 32'(frame_start), 32'd0);

    // Reset while a nonzero row is lit
    found = 1'b0;
    for (int k = 0; k < 2 * ROW_PERIOD && !found; k++) begin
      @(negedge clk_in);
      found = !panel_oe_n && (panel_addr != 0);
    end
    check("found_lit_row", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk_in);
    check("midrst_oe_n", 32'(panel_oe_n), 32'd1);
    check("midrst_addr", 32'(panel_addr), 32'd0);
    check("midrst_lat", 32'(panel_lat), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk_in);
    rst        = 1'b0;
    lat_before = lat_q.size();
    for (int k = 0; k < 2 * ROW_PERIOD && lat_q.size() == lat_before; k++) @(negedge clk_in);
    check("post_rst_lat", 32'(lat_q.size() - lat_before), 32'd1);
    if (lat_q.size() > 0) check("post_rst_lat_addr", 32'(lat_q[$]), 32'd0);
    repeat (ROW_PERIOD) @(negedge clk_in);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
